// File: rtl/mig_u_fetch_ctrl.sv
// Instruction fetch controller: issues SRAM word reads and buffers returned instructions with their PCs.
// Latency: an issued read reaches insn_valid SRAM latency + 1 cycles later (when the buffer is empty).
// Backpressure: credit rule (outstanding + buffered < FIFO_DEPTH) holds off reads so the buffer never overflows.
module mig_u_fetch_ctrl #(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  FIFO_DEPTH     = 4,
    localparam int MEM_ADDR_WIDTH = ADDR_WIDTH - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:2]     rst_addr,
    output logic                      sram_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic                      sram_rd_valid,
    input  logic [31:0]               sram_rd_data,
    input  logic                      redirect_valid,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr,
    output logic                      insn_valid,
    output logic [31:0]               insn_data,
    output logic [MEM_ADDR_WIDTH-1:0] insn_pc,
    input  logic                      insn_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_FETCH = 1'b0, ST_FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic [31:0]               data;
        logic [MEM_ADDR_WIDTH-1:0] pc;
    } entry_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [MEM_ADDR_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [CNT_W-1:0]          outst_q, outst_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    entry_t                    mem_q [FIFO_DEPTH];
    entry_t                    mem_d [FIFO_DEPTH];

    logic                      issue;
    logic                      push;
    logic                      pop;
    logic                      rsp_dec;
    logic [CNT_W:0]            credit_used;

    // Shared control terms: credit check, issue, push and pop qualifiers
    always_comb begin
        credit_used = {1'b0, outst_q} + {1'b0, cnt_q};
        issue       = (state_q == ST_FETCH) && !redirect_valid && !rst &&
                      (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        push        = sram_rd_valid && (state_q == ST_FETCH) && !redirect_valid;
        pop         = insn_valid && insn_ready;
        // A response with nothing outstanding is a protocol error; never let the counter underflow.
        rsp_dec     = sram_rd_valid && (outst_q != '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a redirect or a flush in progress waits until every in-flight read has drained
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (outst_d != '0) ? ST_FLUSH : ST_FETCH;
        end else if (state_q == ST_FLUSH) begin
            state_d = (outst_d != '0) ? ST_FLUSH : ST_FETCH;
        end
    end

    // Outputs: read request and buffer head
    always_comb begin
        sram_rd_en   = issue;
        sram_rd_addr = fetch_pc_q;
        insn_valid   = !rst && (cnt_q != '0);
        insn_data    = mem_q[rd_ptr_q].data;
        insn_pc      = mem_q[rd_ptr_q].pc;
    end

    // Datapath next values: PCs, outstanding-read count and buffer bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ret_pc_d   = ret_pc_q;
        outst_d    = outst_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        case ({issue, rsp_dec})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        if (redirect_valid) begin
            // Any same-cycle pop is already consumed; everything else in the buffer is stale.
            fetch_pc_d = redirect_addr;
            ret_pc_d   = redirect_addr;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + MEM_ADDR_WIDTH'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{data: sram_rd_data, pc: ret_pc_q};
                ret_pc_d        = ret_pc_q + MEM_ADDR_WIDTH'(1);
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= rst_addr;
            ret_pc_q   <= rst_addr;
            outst_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ret_pc_q   <= ret_pc_d;
            outst_q    <= outst_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Buffer storage; contents are only meaningful under cnt_q, so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_mig_u_fetch_ctrl.sv
// Testbench for mig_u_fetch_ctrl: SRAM responder with variable latency plus a transaction-level reference model.
// Latency: checks every cycle on the negative edge after inputs settle.
// Backpressure: insn_ready driven by directed phases and random patterns.
module tb_mig_u_fetch_ctrl;

    localparam int AW    = 32;
    localparam int MAW   = AW - 2;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:2]   rst_addr;
    logic            sram_rd_en;
    logic [MAW-1:0]  sram_rd_addr;
    logic            sram_rd_valid;
    logic [31:0]     sram_rd_data;
    logic            redirect_valid;
    logic [MAW-1:0]  redirect_addr;
    logic            insn_valid;
    logic [31:0]     insn_data;
    logic [MAW-1:0]  insn_pc;
    logic            insn_ready;

    always #5 clk = ~clk;

    mig_u_fetch_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rst_addr       (rst_addr),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_addr   (sram_rd_addr),
        .sram_rd_valid  (sram_rd_valid),
        .sram_rd_data   (sram_rd_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .insn_valid     (insn_valid),
        .insn_data      (insn_data),
        .insn_pc        (insn_pc),
        .insn_ready     (insn_ready)
    );

    typedef struct {
        int             due;
        logic [MAW-1:0] addr;
    } req_t;

    typedef struct {
        logic [31:0]    data;
        logic [MAW-1:0] pc;
    } insn_t;

    // SRAM responder state
    req_t           pend[$];
    int             last_due;
    int             lat_lo;
    int             lat_hi;
    int             cyc;

    // Reference model: what the fetch unit should hold, in terms of PCs, queues and a flushing flag
    logic [MAW-1:0] m_fetch;
    logic [MAW-1:0] m_ret;
    int             m_outst;
    insn_t          m_fifo[$];
    bit             m_flush;

    int             n_checks;
    int             n_errors;

    function automatic logic [31:0] mem_word(input logic [MAW-1:0] a);
        return {a[27:0], 4'h9} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model across the edge
    task automatic step(input logic r, input logic rv, input logic [MAW-1:0] ra, input logic rdy);
        logic   exp_en;
        logic   exp_vld;
        logic   rvld;
        logic   pop;
        int     outst_new;
        req_t   rq;
        insn_t  ent;

        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_addr  = ra;
        insn_ready     = rdy;
        rvld           = 1'b0;
        sram_rd_data   = 32'h0;
        if (!r && pend.size() > 0 && pend[0].due <= cyc) begin
            rq           = pend.pop_front();
            rvld         = 1'b1;
            sram_rd_data = mem_word(rq.addr);
        end
        sram_rd_valid = rvld;
        #1;

        exp_en  = !r && !m_flush && !rv && ((m_outst + m_fifo.size()) < DEPTH);
        exp_vld = !r && (m_fifo.size() > 0);
        check_val("sram_rd_en", 64'(sram_rd_en), 64'(exp_en));
        if (exp_en) check_val("sram_rd_addr", 64'(sram_rd_addr), 64'(m_fetch));
        check_val("insn_valid", 64'(insn_valid), 64'(exp_vld));
        if (exp_vld) begin
            check_val("insn_data", 64'(insn_data), 64'(m_fifo[0].data));
            check_val("insn_pc", 64'(insn_pc), 64'(m_fifo[0].pc));
        end

        // SRAM accepts the real request; it is reset together with the fetch unit
        if (r) begin
            pend.delete();
            last_due = cyc;
        end else if (sram_rd_en) begin
            rq.addr = sram_rd_addr;
            rq.due  = cyc + $urandom_range(lat_hi, lat_lo);
            if (rq.due <= last_due) rq.due = last_due + 1;
            last_due = rq.due;
            pend.push_back(rq);
        end

        // Model update for this edge
        if (r) begin
            m_fetch = rst_addr;
            m_ret   = rst_addr;
            m_outst = 0;
            m_fifo.delete();
            m_flush = 1'b0;
        end else begin
            pop       = exp_vld && rdy;
            outst_new = m_outst + (exp_en ? 1 : 0) - (rvld ? 1 : 0);
            if (pop) ent = m_fifo.pop_front();
            if (rv) begin
                m_fetch = ra;
                m_ret   = ra;
                m_fifo.delete();
                m_flush = (outst_new > 0);
            end else if (m_flush) begin
                m_flush = (outst_new > 0);
            end else begin
                if (exp_en) m_fetch = m_fetch + 1'b1;
                if (rvld) begin
                    ent.data = sram_rd_data;
                    ent.pc   = m_ret;
                    m_fifo.push_back(ent);
                    m_ret = m_ret + 1'b1;
                end
            end
            m_outst = outst_new;
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy);
    endtask

    initial begin
        logic [MAW-1:0] ra;
        logic           rv;
        logic           r;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        last_due = 0;
        m_fetch  = '0;
        m_ret    = '0;
        m_outst  = 0;
        m_flush  = 1'b0;
        rst            = 1'b1;
        rst_addr       = 30'h100;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        sram_rd_valid  = 1'b0;
        sram_rd_data   = '0;
        insn_ready     = 1'b0;

        // Streaming from 0x100 with single-cycle SRAM and an always-ready consumer
        lat_lo = 1; lat_hi = 1;
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 30'h55, 1'b1);
        run(20, 1'b1);

        // Stalled consumer: buffer fills, reads stop; then single pops each free one read
        run(10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            run(4, 1'b0);
        end

        // Redirect to 0x40 with reads in flight on a slow SRAM
        lat_lo = 3; lat_hi = 3;
        run(6, 1'b1);
        step(1'b0, 1'b1, 30'h40, 1'b1);
        run(12, 1'b1);

        // Redirect coinciding with a returning response and a handshake
        lat_lo = 1; lat_hi = 2;
        for (int i = 0; i < 40; i++) begin
            if (sram_rd_valid === 1'b0 && pend.size() > 0 && pend[0].due == cyc && insn_valid) begin
                step(1'b0, 1'b1, 30'h200, 1'b1);
                break;
            end
            step(1'b0, 1'b0, '0, 1'b1);
        end
        run(10, 1'b1);

        // PC wrap from all-ones to zero
        step(1'b0, 1'b1, 30'h3FFF_FFFE, 1'b1);
        run(12, 1'b1);

        // Reset in the middle of a full buffer, then refetch from a new reset address
        run(10, 1'b0);
        rst_addr = 30'h0ABC;
        step(1'b1, 1'b0, '0, 1'b0);
        run(10, 1'b1);

        // Randomized traffic
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(99) == 0);
            rv = ($urandom_range(15) == 0);
            ra = ($urandom_range(3) == 0) ? (30'h3FFF_FFFC + 30'($urandom_range(3))) : 30'($urandom);
            if (r) rst_addr = 30'($urandom);
            step(r, rv, ra, ($urandom_range(9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
